digit_entry_ctrl: RTL

Front-end write controller for the 8-digit seven-segment display register file. It debounces two raw push-buttons and samples a 4-bit switch value. It then produces the `wr`/`num`/`sel` write stream consumed by the display's digit storage stage. It provides auto-incrementing digit entry and an 8-cycle clear-all sweep.

---
 rtl/digit_entry_pkg.sv | 17 +
 rtl/digit_entry_ctrl_button_debouncer.sv | 59 +++++
 rtl/digit_entry_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/digit_entry_pkg.sv
// Shared types and sizes for the digit entry write controller.
package digit_entry_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int SEL_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Index of the final digit touched by a clear sweep.
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

endpackage

// File: rtl/digit_entry_ctrl_button_debouncer.sv
// Raw push-button conditioning: 2-flop synchronizer, level debouncer,
// and a one-cycle pulse on each debounced rising edge (press only).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic             r_db_d;
    logic [CNT_W-1:0] r_cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Flip the debounced level only after a full run of disagreeing samples;
    // any agreeing sample restarts the run.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (r_sync2 == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_db  <= r_sync2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_db_d <= 1'b0;
        end else begin
            r_db_d <= r_db;
        end
    end

    assign press = r_db & ~r_db_d;

endmodule

// File: rtl/digit_entry_ctrl.sv
// Write-stream generator for the 8-digit display register file:
// one store per "wr" press at an auto-incrementing digit, or an
// 8-cycle zero sweep on a "clr" press. All outputs come from flops.
//
// state | meaning
// IDLE  | waiting for a debounced press, outputs quiet
// WRITE | single-cycle store of the captured switch value at ptr
// CLEAR | writing zero to digits 0..7, one per cycle
module digit_entry_ctrl
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               btn_wr,
    input  logic               btn_clr,
    input  logic [DIGIT_W-1:0] sw_num,
    output logic               wr,
    output logic [DIGIT_W-1:0] num,
    output logic [SEL_W-1:0]   sel,
    output logic               busy
);

    logic w_press_wr;
    logic w_press_clr;

    state_t             r_state;
    logic               r_wr;
    logic [DIGIT_W-1:0] r_num;
    logic [SEL_W-1:0]   r_sel;
    logic               r_busy;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   r_clr_idx;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_wr (
        .CLK     (CLK),
        .rst     (rst),
        .btn_raw (btn_wr),
        .press   (w_press_wr)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_clr (
        .CLK     (CLK),
        .rst     (rst),
        .btn_raw (btn_clr),
        .press   (w_press_clr)
    );

    // Sequencer: outputs are set on the edge that enters each state, so the
    // write strobe lines up with the state it belongs to. Presses seen
    // outside IDLE are dropped; clear wins over a simultaneous write.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wr      <= 1'b0;
            r_num     <= '0;
            r_sel     <= '0;
            r_busy    <= 1'b0;
            r_ptr     <= '0;
            r_clr_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_press_clr) begin
                        r_state   <= CLEAR;
                        r_clr_idx <= '0;
                        r_wr      <= 1'b1;
                        r_num     <= '0;
                        r_sel     <= '0;
                        r_busy    <= 1'b1;
                    end else if (w_press_wr) begin
                        r_state <= WRITE;
                        r_wr    <= 1'b1;
                        r_num   <= sw_num;
                        r_sel   <= r_ptr;
                        r_busy  <= 1'b1;
                    end else begin
                        r_wr   <= 1'b0;
                        r_busy <= 1'b0;
                    end
                end
                WRITE: begin
                    r_state <= IDLE;
                    r_wr    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ptr   <= r_ptr + SEL_W'(1);
                end
                CLEAR: begin
                    if (r_clr_idx == LAST_SEL) begin
                        r_state <= IDLE;
                        r_wr    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ptr   <= '0;
                    end else begin
                        r_clr_idx <= r_clr_idx + SEL_W'(1);
                        r_sel     <= r_clr_idx + SEL_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_wr    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wr   = r_wr;
    assign num  = r_num;
    assign sel  = r_sel;
    assign busy = r_busy;

endmodule
